// File: rtl/pe_group_sched.sv
// pe_group_sched
// Sequencer for one 8-in/4-out tanh processing element that is time-shared
// across a reservoir. One reservoir update walks N_GROUPS output groups:
// each group index is issued to the weight ROM and the input-state mux.
// After the ROM read and PE pipeline latency, the matching PE result is
// written into the next-state buffer. swap/done pulse when the update ends.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous reset, active high
//   start     in   1       request one reservoir update (sampled in IDLE only)
//   busy      out  1       update in progress
//   done      out  1       1-cycle pulse, update complete
//   swap      out  1       1-cycle pulse, flip the state ping-pong buffer
//   grp_addr  out  ADDR_W  group index to weight ROM and input-state mux
//   pe_ce     out  1       PE output-register enable (equals busy)
//   wr_en     out  1       write current PE Q into the next-state buffer
//   wr_addr   out  ADDR_W  group index for wr_en
//
// Optional feature macro: PE_GROUP_SCHED_MULTISTEP_EN
//   When defined, adds n_steps [15:0] (sampled with start) and
//   step_cnt [15:0]. n_steps updates then run back to back. swap pulses
//   after every update. done pulses only after the last update.
//   n_steps = 0 behaves as 1.
module pe_group_sched #(
  parameter int WORD_LEN = 16,
  parameter int NEU_IN   = 8,
  parameter int NEU_OUT  = 4,
  parameter int N_GROUPS = 8,
  parameter int ADDR_W   = 3,
  parameter int PE_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              swap,
  output logic [ADDR_W-1:0] grp_addr,
  output logic              pe_ce,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
`ifdef PE_GROUP_SCHED_MULTISTEP_EN
  ,
  input  logic [15:0]       n_steps,
  output logic [15:0]       step_cnt
`endif
);

  // ROM read latency plus PE latency.
  localparam int LAT = 1 + PE_LAT;

  // Reject configurations that cannot work.
  generate
    if (N_GROUPS < 1 || (2 ** ADDR_W) < N_GROUPS || PE_LAT < 0 ||
        WORD_LEN < 1 || NEU_IN < 1 || NEU_OUT < 1) begin : g_bad_cfg
      $error("pe_group_sched: invalid parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              pv_r [LAT];
  logic [ADDR_W-1:0] pa_r [LAT];
  logic              last_grp_s;
  logic              last_wr_s;
  logic              last_step_s;

  // The terminal group is detected with an exact compare, so a counter
  // wider than N_GROUPS never wraps.
  assign last_grp_s = (grp_addr == ADDR_W'(N_GROUPS - 1));
  assign last_wr_s  = wr_en && (wr_addr == ADDR_W'(N_GROUPS - 1));

  // Writes come straight from the last stage of the delay line.
  assign wr_en   = pv_r[LAT-1];
  assign wr_addr = pa_r[LAT-1];

`ifdef PE_GROUP_SCHED_MULTISTEP_EN
  logic [15:0] n_last_r;
  assign last_step_s = (step_cnt == n_last_r);
`else
  assign last_step_s = 1'b1;
`endif

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = ISSUE;
        else       state_nx_s = IDLE;
      end
      ISSUE: begin
        if (last_grp_s) state_nx_s = DRAIN;
        else            state_nx_s = ISSUE;
      end
      DRAIN: begin
        if (last_wr_s) state_nx_s = FIN;
        else           state_nx_s = DRAIN;
      end
      FIN: begin
        // Between steps, go straight back to ISSUE so busy never drops.
        if (last_step_s) state_nx_s = IDLE;
        else             state_nx_s = ISSUE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register, registered outputs and the write delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      pe_ce    <= 1'b0;
      done     <= 1'b0;
      swap     <= 1'b0;
      grp_addr <= {ADDR_W{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        pv_r[i] <= 1'b0;
        pa_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      state_r <= state_nx_s;
      // Outputs are decoded from the next state so they line up with it.
      busy  <= (state_nx_s == ISSUE) || (state_nx_s == DRAIN) ||
               ((state_nx_s == FIN) && !last_step_s);
      pe_ce <= (state_nx_s == ISSUE) || (state_nx_s == DRAIN) ||
               ((state_nx_s == FIN) && !last_step_s);
      done  <= (state_nx_s == FIN) && last_step_s;
      swap  <= (state_nx_s == FIN);
      if (state_nx_s == ISSUE) begin
        if (state_r == ISSUE) grp_addr <= grp_addr + ADDR_W'(1);
        else                  grp_addr <= {ADDR_W{1'b0}};
      end else begin
        grp_addr <= grp_addr;
      end
      // A group present on grp_addr during ISSUE reaches wr_en LAT cycles later.
      pv_r[0] <= (state_r == ISSUE);
      pa_r[0] <= grp_addr;
      for (int i = 1; i < LAT; i++) begin
        pv_r[i] <= pv_r[i-1];
        pa_r[i] <= pa_r[i-1];
      end
    end
  end

`ifdef PE_GROUP_SCHED_MULTISTEP_EN
  // Step bookkeeping: the index advances when the next step's ISSUE begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= 16'd0;
      n_last_r <= 16'd0;
    end else if (state_r == IDLE && state_nx_s == ISSUE) begin
      step_cnt <= 16'd0;
      n_last_r <= (n_steps == 16'd0) ? 16'd0 : (n_steps - 16'd1);
    end else if (state_r == FIN && state_nx_s == ISSUE) begin
      step_cnt <= step_cnt + 16'd1;
      n_last_r <= n_last_r;
    end else if (state_nx_s == IDLE) begin
      step_cnt <= 16'd0;
      n_last_r <= n_last_r;
    end else begin
      step_cnt <= step_cnt;
      n_last_r <= n_last_r;
    end
  end
`endif

endmodule

// File: tb/tb_pe_group_sched.sv
// Scoreboard bench for pe_group_sched (default parameters plus a
// N_GROUPS=1 / PE_LAT=0 instance). Expected values are pushed when stimulus
// is issued. A negedge monitor pops and compares them.
module tb_pe_group_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, swap, pe_ce, wr_en;
  logic [2:0] grp_addr, wr_addr;
  logic       start1;
  logic       busy1, done1, swap1, pe_ce1, wr_en1;
  logic [0:0] grp_addr1, wr_addr1;
`ifdef PE_GROUP_SCHED_MULTISTEP_EN
  logic [15:0] n_steps, step_cnt, step_cnt1;
  logic [15:0] n_steps1 = 16'd1;
`endif

  always #5 clk = ~clk;

  pe_group_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .swap(swap),
    .grp_addr(grp_addr), .pe_ce(pe_ce), .wr_en(wr_en), .wr_addr(wr_addr)
`ifdef PE_GROUP_SCHED_MULTISTEP_EN
    , .n_steps(n_steps), .step_cnt(step_cnt)
`endif
  );

  pe_group_sched #(.N_GROUPS(1), .ADDR_W(1), .PE_LAT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .swap(swap1),
    .grp_addr(grp_addr1), .pe_ce(pe_ce1), .wr_en(wr_en1), .wr_addr(wr_addr1)
`ifdef PE_GROUP_SCHED_MULTISTEP_EN
    , .n_steps(n_steps1), .step_cnt(step_cnt1)
`endif
  );

  typedef struct {int cyc; int kind; int val;} exp_t;  // kind 0 grp_addr,1 busy,2 pe_ce,3 step_cnt
  typedef struct {int cyc; int addr;} wr_t;

  exp_t trace_q[$];
  wr_t  wr_q[$];
  int   done_q[$];
  int   swap_q[$];
  int   now = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) now <= now + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, now);
    end
  endtask

  task automatic push_tr(input int cyc, input int kind, input int val);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = val;
    trace_q.push_back(e);
  endtask

  task automatic push_wr(input int cyc, input int addr);
    wr_t w;
    w.cyc = cyc; w.addr = addr;
    wr_q.push_back(w);
  endtask

  // Expected response of n_upd back-to-back single updates (period 13),
  // the first one starting at relative cycle 1 after base b.
  task automatic push_run(input int b, input int n_upd, input int r_end);
    int o, rr;
    for (int r = 1; r <= r_end; r++) begin
      o = ((r - 1) / 13) * 13;
      if (o >= 13 * n_upd) o = 13 * (n_upd - 1);
      rr = r - o;
      push_tr(b + r, 0, (rr <= 8) ? rr - 1 : 7);
      push_tr(b + r, 1, (rr >= 1 && rr <= 11) ? 1 : 0);
      push_tr(b + r, 2, (rr >= 1 && rr <= 11) ? 1 : 0);
    end
    for (int u = 0; u < n_upd; u++) begin
      for (int g = 0; g < 8; g++) push_wr(b + 13 * u + 4 + g, g);
      done_q.push_back(b + 13 * u + 12);
      swap_q.push_back(b + 13 * u + 12);
    end
  endtask

  task automatic wait_rel(input int b, input int r);
    while (now < b + r) @(negedge clk);
  endtask

  // Monitor: compare traces due this cycle and every presented write/pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    wr_t  w;
    int   d;
    while (trace_q.size() > 0 && trace_q[0].cyc <= now) begin
      e = trace_q.pop_front();
      case (e.kind)
        0: check("grp_addr", grp_addr, e.val);
        1: check("busy", busy, e.val);
        2: check("pe_ce", pe_ce, e.val);
`ifdef PE_GROUP_SCHED_MULTISTEP_EN
        3: check("step_cnt", step_cnt, e.val);
`endif
        default: check("trace_kind", e.kind, 0);
      endcase
    end
    if (wr_en === 1'b1) begin
      if (wr_q.size() == 0) check("wr_unexpected_cycle", now, -1);
      else begin
        w = wr_q.pop_front();
        check("wr_cycle", now, w.cyc);
        check("wr_addr", wr_addr, w.addr);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) check("done_unexpected_cycle", now, -1);
      else begin d = done_q.pop_front(); check("done_cycle", now, d); end
    end
    if (swap === 1'b1) begin
      if (swap_q.size() == 0) check("swap_unexpected_cycle", now, -1);
      else begin d = swap_q.pop_front(); check("swap_cycle", now, d); end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
`ifdef PE_GROUP_SCHED_MULTISTEP_EN
    n_steps = 16'd1;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);   check("rst_done", done, 0);
    check("rst_swap", swap, 0);   check("rst_grp_addr", grp_addr, 0);
    check("rst_pe_ce", pe_ce, 0); check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: single update.
    b = now; push_run(b, 1, 14);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_rel(b, 16);

    // Test 2: start pulsed during ISSUE is ignored.
    b = now; push_run(b, 1, 14);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_rel(b, 5); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_rel(b, 16);

    // Test 3: reset mid-update kills the pending writes.
    b = now;
    for (int r = 1; r <= 10; r++) begin
      push_tr(b + r, 0, (r <= 6) ? r - 1 : 0);
      push_tr(b + r, 1, (r <= 6) ? 1 : 0);
      push_tr(b + r, 2, (r <= 6) ? 1 : 0);
    end
    for (int g = 0; g < 3; g++) push_wr(b + 4 + g, g);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_rel(b, 6); rst = 1'b1;
    wait_rel(b, 7); rst = 1'b0;
    check("rst_mid_done", done, 0);
    check("rst_mid_wr_en", wr_en, 0);
    wait_rel(b, 12);

    // Test 4: start held high gives back-to-back updates.
    b = now; push_run(b, 2, 27);
    start = 1'b1;
    wait_rel(b, 14); start = 1'b0;
    wait_rel(b, 30);

    // Test 5: N_GROUPS=1, PE_LAT=0 instance.
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    check("g1_c1_grp_addr", grp_addr1, 0); check("g1_c1_busy", busy1, 1);
    check("g1_c1_wr_en", wr_en1, 0);
    @(negedge clk);
    check("g1_c2_wr_en", wr_en1, 1); check("g1_c2_wr_addr", wr_addr1, 0);
    check("g1_c2_done", done1, 0);
    @(negedge clk);
    check("g1_c3_done", done1, 1); check("g1_c3_swap", swap1, 1);
    check("g1_c3_busy", busy1, 0); check("g1_c3_wr_en", wr_en1, 0);
    @(negedge clk);
    check("g1_c4_done", done1, 0);

`ifdef PE_GROUP_SCHED_MULTISTEP_EN
    // Test 6: three chained steps.
    b = now; n_steps = 16'd3;
    for (int r = 1; r <= 37; r++) begin
      int j, rr;
      j = (r - 1) / 12; if (j > 2) j = 2;
      rr = r - 12 * j;
      push_tr(b + r, 0, (rr <= 8) ? rr - 1 : 7);
      push_tr(b + r, 1, (r <= 35) ? 1 : 0);
      push_tr(b + r, 3, (r <= 36) ? j : 0);
    end
    for (int s = 0; s < 3; s++) begin
      for (int g = 0; g < 8; g++) push_wr(b + 12 * s + 4 + g, g);
      swap_q.push_back(b + 12 * s + 12);
    end
    done_q.push_back(b + 36);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_rel(b, 40);
    n_steps = 16'd1;
`endif

    repeat (3) @(negedge clk);
    check("trace_q_empty", trace_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("swap_q_empty", swap_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
